// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: opcodes, FSM states, instruction classes and datapath select encodings
// shared by the multicycle control unit and the datapath (imm_gen uses the IMM_* codes).
package rv_ctrl_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;

    typedef enum logic [3:0] {
        C_OP, C_OP_IMM, C_LOAD, C_STORE, C_LUI, C_AUIPC, C_BRANCH, C_JAL, C_JALR, C_ILLEGAL
    } cls_e;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_REL   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode to instruction class and immediate format decoder.
module ctrl_decode import rv_ctrl_pkg::*; (
    input  logic [6:0] opcode_i,
    output cls_e       cls_o,
    output logic [2:0] imm_sel_o
);
    always_comb begin
        cls_o     = C_ILLEGAL;
        imm_sel_o = IMM_I;
        case (opcode_i)
            OPC_OP:     cls_o = C_OP;
            OPC_OP_IMM: cls_o = C_OP_IMM;
            OPC_LOAD:   cls_o = C_LOAD;
            OPC_STORE:  begin cls_o = C_STORE;  imm_sel_o = IMM_S; end
            OPC_LUI:    begin cls_o = C_LUI;    imm_sel_o = IMM_U; end
            OPC_AUIPC:  begin cls_o = C_AUIPC;  imm_sel_o = IMM_U; end
            OPC_BRANCH: begin cls_o = C_BRANCH; imm_sel_o = IMM_B; end
            OPC_JAL:    begin cls_o = C_JAL;    imm_sel_o = IMM_J; end
            OPC_JALR:   cls_o = C_JALR;
            default:    ;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencing one RV32I instruction at a time and driving every datapath control.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes; otherwise they execute as NOPs.
module multicycle_ctrl import rv_ctrl_pkg::*; #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [2:0]  imm_sel,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        trap,
    output logic        bus_err
);
`ifdef ILLEGAL_TRAP_EN
    localparam state_e illegal_next = S_TRAP;
`else
    localparam state_e illegal_next = S_FETCH;
`endif
    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       bus_err_q, bus_err_d;
    cls_e       cls;
    logic [2:0] dec_imm;
    logic       waiting, timeout, rd_nz, exec_st, held, jump, unused_instr;

    ctrl_decode u_decode (.opcode_i(instr[6:0]), .cls_o(cls), .imm_sel_o(dec_imm));

    assign unused_instr = ^instr[31:12];
    assign rd_nz        = |instr[11:7];
    assign waiting      = state_q == S_FETCH || state_q == S_MEM;
    // a handshake in the final count cycle still completes
    assign timeout      = waiting && !mem_ready && wait_cnt_q == 8'(MEM_TIMEOUT - 1);
    assign state        = state_q;
    assign bus_err      = bus_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 8'd0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = timeout ? S_TRAP : mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = cls inside {C_LOAD, C_STORE} ? S_MEM :
                                cls inside {C_OP, C_OP_IMM, C_LUI, C_AUIPC} ? S_WB :
                                cls == C_ILLEGAL ? illegal_next : S_FETCH;
            S_MEM:    state_d = timeout ? S_TRAP : !mem_ready ? S_MEM : cls == C_STORE ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_TRAP;
        endcase
        wait_cnt_d = (waiting && !mem_ready) ? wait_cnt_q + 8'd1 : 8'd0;
        bus_err_d  = bus_err_q || timeout;
    end

    // operand selects stay valid past EXEC so the ALU result is stable for MEM address and WB
    always_comb begin
        exec_st   = state_q == S_EXEC;
        held      = state_q inside {S_EXEC, S_MEM, S_WB};
        jump      = exec_st && (cls == C_JAL || cls == C_JALR);
        imem_req  = state_q == S_FETCH;
        ir_we     = imem_req && mem_ready;
        dmem_req  = state_q == S_MEM;
        dmem_we   = dmem_req && cls == C_STORE;
        pc_we     = ir_we || jump || (exec_st && cls == C_BRANCH && branch_taken);
        pc_sel    = !exec_st ? PC_PLUS4 : cls == C_JALR ? PC_JALR :
                    cls inside {C_BRANCH, C_JAL} ? PC_REL : PC_PLUS4;
        rf_we     = rd_nz && (jump || state_q == S_WB);
        wb_sel    = jump ? WB_PC4 : state_q != S_WB ? WB_ALU :
                    cls == C_LOAD ? WB_MEM : cls == C_LUI ? WB_IMM : WB_ALU;
        imm_sel   = (held || state_q == S_DECODE) ? dec_imm : IMM_I;
        alu_src_a = held && cls == C_AUIPC;
        alu_src_b = held && cls inside {C_OP_IMM, C_LOAD, C_STORE, C_AUIPC, C_JALR};
        trap      = state_q == S_TRAP;
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle expected control outputs built from the instruction-level
// sequencing rules, driven with randomized memory latency and don't-care inputs.
module tb_multicycle_ctrl;
    import rv_ctrl_pkg::*;

    localparam int TO = 4;

    logic        clk = 0, rst_n = 0, mem_ready = 0, branch_taken = 0;
    logic [31:0] instr = 0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, alu_src_a, alu_src_b, trap, bus_err;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  imm_sel, state;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .rf_we(rf_we), .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .wb_sel(wb_sel), .state(state), .trap(trap), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic trap, berr, imem, dmem, dwe, irwe, pcwe, rfwe;
        logic [1:0] pcsel;
        logic [2:0] imm;
        logic a, b;
        logic [1:0] wb;
    } out_t;

    typedef struct packed {
        logic rdy, tk;
        logic [31:0] ins;
        out_t e;
    } step_t;

    step_t       exp_q[$];
    out_t        got_q[$];
    int          n_checks = 0, n_fail = 0;
    logic [31:0] ir_now = 0;
    bit          dead = 0;
    out_t        got, m;

    function automatic out_t sample();
        out_t o;
        o = '{state, trap, bus_err, imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we,
              pc_sel, imm_sel, alu_src_a, alu_src_b, wb_sel};
        return o;
    endfunction

    function automatic out_t ost(state_e s);
        out_t e = '0;
        e.st = s;
        return e;
    endfunction

    // selects are only meaningful while their enable/state uses them; in IDLE/TRAP everything is checked
    function automatic out_t care(out_t e);
        out_t k = '1;
        if (e.st != S_IDLE && e.st != S_TRAP) begin
            if (!e.pcwe) k.pcsel = '0;
            if (!e.rfwe) k.wb = '0;
            if (e.st != S_EXEC) begin k.a = 1'b0; k.b = 1'b0; end
            if (e.st == S_FETCH) k.imm = '0;
        end
        return k;
    endfunction

    function automatic void push(logic rdy, logic tk, logic [31:0] ins, out_t e);
        step_t s;
        s.rdy = rdy; s.tk = tk; s.ins = ins; s.e = e;
        exp_q.push_back(s);
    endfunction

    function automatic void push_trap(logic berr);
        out_t e = ost(S_TRAP);
        e.trap = 1'b1;
        e.berr = berr;
        for (int j = 0; j < 3; j++) push(1'($urandom), 1'($urandom), ir_now, e);
        dead = 1;
    endfunction

    // w not-ready cycles then a ready one; TO consecutive not-ready cycles end in a bus error
    function automatic bit wait_phase(state_e s, int w, out_t e0);
        for (int k = 0; k <= w; k++) begin
            out_t e = e0;
            if (k == TO) begin push_trap(1'b1); return 1; end
            if (s == S_FETCH) begin e.irwe = (k == w); e.pcwe = (k == w); end
            push(k == w, 1'($urandom), ir_now, e);
        end
        return 0;
    endfunction

    function automatic void add_instr(logic [31:0] ins, int fw, int mw, logic tk);
        logic [6:0] op = ins[6:0];
        logic wr = |ins[11:7];
        bit ld = op == 7'h03, sw = op == 7'h23, lui = op == 7'h37, aui = op == 7'h17;
        bit br = op == 7'h63, jal = op == 7'h6f, jalr = op == 7'h67, alu = op == 7'h33, alui = op == 7'h13;
        logic [2:0] imm = sw ? 3'd1 : br ? 3'd2 : (lui || aui) ? 3'd3 : jal ? 3'd4 : 3'd0;
        out_t e;
        if (dead) return;
        e = ost(S_FETCH); e.imem = 1'b1;
        if (wait_phase(S_FETCH, fw, e)) return;
        ir_now = ins;
        e = ost(S_DECODE); e.imm = imm;
        push(1'($urandom), 1'($urandom), ins, e);
        e = ost(S_EXEC); e.imm = imm;
        e.a = aui;
        e.b = alui || ld || sw || aui || jalr;
        if (br) begin e.pcwe = tk; e.pcsel = 2'd1; end
        if (jal || jalr) begin e.rfwe = wr; e.wb = 2'd2; e.pcwe = 1'b1; e.pcsel = jal ? 2'd1 : 2'd2; end
        push(1'($urandom), tk, ins, e);
        if (!(ld || sw || lui || aui || br || jal || jalr || alu || alui)) begin
`ifdef ILLEGAL_TRAP_EN
            push_trap(1'b0);
`endif
            return;
        end
        if (ld || sw) begin
            e = ost(S_MEM); e.imm = imm; e.dmem = 1'b1; e.dwe = sw;
            if (wait_phase(S_MEM, mw, e)) return;
        end
        if (!(br || jal || jalr || sw)) begin
            e = ost(S_WB); e.imm = imm; e.rfwe = wr; e.wb = ld ? 2'd1 : lui ? 2'd3 : 2'd0;
            push(1'($urandom), 1'($urandom), ins, e);
        end
    endfunction

    task automatic run_steps();
        foreach (exp_q[i]) begin
            mem_ready    = exp_q[i].rdy;
            branch_taken = exp_q[i].tk;
            instr        = exp_q[i].ins;
            @(negedge clk);
            got_q.push_back(sample());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 0;
        mem_ready = 0;
        exp_q.delete();
        got_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1;
        dead = 0;
        ir_now = instr;
        push(1'($urandom), 1'($urandom), ir_now, ost(S_IDLE));
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        got = sample();
        n_checks++;
        if (got !== ost(S_IDLE)) begin n_fail++; $display("FAIL reset_state: got %h, expected %h", got, ost(S_IDLE)); end
        apply_reset();
        add_instr(32'h00000013, 0, 0, 1'b0);
        run_steps();
        foreach (exp_q[i]) begin
            m = care(exp_q[i].e);
            n_checks++;
            if ((got_q[i] & m) !== (exp_q[i].e & m)) begin
                n_fail++; $display("FAIL reset_release step %0d: got %h, expected %h", i, got_q[i] & m, exp_q[i].e & m);
            end
        end
    endtask

    task automatic test_addi();
        apply_reset();
        add_instr(32'hf9c30293, 0, 0, 1'b1);
        add_instr(32'hf9c30293, 2, 0, 1'b0);
        run_steps();
        foreach (exp_q[i]) begin
            m = care(exp_q[i].e);
            n_checks++;
            if ((got_q[i] & m) !== (exp_q[i].e & m)) begin
                n_fail++; $display("FAIL addi step %0d: got %h, expected %h", i, got_q[i] & m, exp_q[i].e & m);
            end
        end
    endtask

    task automatic test_load_store();
        apply_reset();
        add_instr(32'h0c832283, 0, 0, 1'b0);
        add_instr(32'h0c532423, 0, 0, 1'b1);
        add_instr(32'h0c832283, 1, 2, 1'b1);
        add_instr(32'h0c532423, 2, 1, 1'b0);
        add_instr(32'h00000013, 0, 0, 1'b0);
        run_steps();
        foreach (exp_q[i]) begin
            m = care(exp_q[i].e);
            n_checks++;
            if ((got_q[i] & m) !== (exp_q[i].e & m)) begin
                n_fail++; $display("FAIL load_store step %0d: got %h, expected %h", i, got_q[i] & m, exp_q[i].e & m);
            end
        end
    endtask

    task automatic test_branch();
        apply_reset();
        add_instr(32'h02528063, 0, 0, 1'b1);
        add_instr(32'h02528063, 0, 0, 1'b0);
        add_instr(32'h02528063, 1, 0, 1'b1);
        add_instr(32'h00000013, 0, 0, 1'b1);
        run_steps();
        foreach (exp_q[i]) begin
            m = care(exp_q[i].e);
            n_checks++;
            if ((got_q[i] & m) !== (exp_q[i].e & m)) begin
                n_fail++; $display("FAIL branch step %0d: got %h, expected %h", i, got_q[i] & m, exp_q[i].e & m);
            end
        end
    endtask

    task automatic test_jalr_rd0();
        apply_reset();
        add_instr(32'h100302e7, 0, 0, 1'b0);
        add_instr(32'h008000ef, 0, 0, 1'b1);
        add_instr(32'h00000013, 0, 0, 1'b0);
        add_instr(32'h00030067, 0, 0, 1'b1);
        add_instr(32'h12345037, 0, 0, 1'b0);
        add_instr(32'h00001097, 0, 0, 1'b0);
        run_steps();
        foreach (exp_q[i]) begin
            m = care(exp_q[i].e);
            n_checks++;
            if ((got_q[i] & m) !== (exp_q[i].e & m)) begin
                n_fail++; $display("FAIL jalr_rd0 step %0d: got %h, expected %h", i, got_q[i] & m, exp_q[i].e & m);
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        add_instr(32'hf9c30293, TO, 0, 1'b0);
        run_steps();
        apply_reset();
        add_instr(32'hf9c30293, TO - 1, 0, 1'b0);
        add_instr(32'h0c532423, 0, TO - 1, 1'b0);
        add_instr(32'h0c832283, 0, TO, 1'b0);
        run_steps();
        foreach (exp_q[i]) begin
            m = care(exp_q[i].e);
            n_checks++;
            if ((got_q[i] & m) !== (exp_q[i].e & m)) begin
                n_fail++; $display("FAIL timeout step %0d: got %h, expected %h", i, got_q[i] & m, exp_q[i].e & m);
            end
        end
    endtask

    task automatic test_reset_mid_mem_illegal();
        apply_reset();
        add_instr(32'h0c532423, 0, 3, 1'b0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        run_steps();
        foreach (exp_q[i]) begin
            m = care(exp_q[i].e);
            n_checks++;
            if ((got_q[i] & m) !== (exp_q[i].e & m)) begin
                n_fail++; $display("FAIL store_wait step %0d: got %h, expected %h", i, got_q[i] & m, exp_q[i].e & m);
            end
        end
        mem_ready = 1;
        rst_n = 0;
        #1;
        got = sample();
        n_checks++;
        if (got !== ost(S_IDLE)) begin n_fail++; $display("FAIL reset_mid_mem: got %h, expected %h", got, ost(S_IDLE)); end
        @(posedge clk);
        #1;
        got = sample();
        n_checks++;
        if (got !== ost(S_IDLE)) begin n_fail++; $display("FAIL reset_hold_mem: got %h, expected %h", got, ost(S_IDLE)); end
        rst_n = 1;
        dead = 0;
        exp_q.delete();
        got_q.delete();
        push(1'b1, 1'b0, ir_now, ost(S_IDLE));
        add_instr(32'h0000007f, 0, 0, 1'b1);
        add_instr(32'hf9c30293, 0, 0, 1'b0);
        run_steps();
        foreach (exp_q[i]) begin
            m = care(exp_q[i].e);
            n_checks++;
            if ((got_q[i] & m) !== (exp_q[i].e & m)) begin
                n_fail++; $display("FAIL illegal step %0d: got %h, expected %h", i, got_q[i] & m, exp_q[i].e & m);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6f, 7'h67};
        apply_reset();
        for (int n = 0; n < 30; n++) begin
            logic [31:0] r = $urandom;
            add_instr({r[31:7], ops[$urandom_range(0, 8)]}, $urandom_range(0, TO - 1),
                      $urandom_range(0, TO - 1), 1'($urandom));
        end
        run_steps();
        foreach (exp_q[i]) begin
            m = care(exp_q[i].e);
            n_checks++;
            if ((got_q[i] & m) !== (exp_q[i].e & m)) begin
                n_fail++; $display("FAIL random step %0d: got %h, expected %h", i, got_q[i] & m, exp_q[i].e & m);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_addi();
        test_load_store();
        test_branch();
        test_jalr_rd0();
        test_timeout();
        test_reset_mid_mem_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the unpipelined RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback, and drives every datapath select and write-enable: PC, IR, register file, immediate generator, ALU operand muxes, writeback mux and the memory request lines. It sits beside the datapath, which holds the PC, the IR and old_pc (latched on `ir_we`), the register file, `imm_gen`, the ALU and the branch comparator.

## Interface
- `MEM_TIMEOUT`, default 15: consecutive not-ready cycles allowed in a memory wait before a bus error; legal range 1..255.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `instr` in 32: current IR contents; valid from DECODE onward.
- `mem_ready` in 1: shared memory handshake, completes the current `imem_req`/`dmem_req`.
- `branch_taken` in 1: comparator result for the current B-type instruction.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data request.
- `dmem_we` out 1: data request is a store.
- `ir_we` out 1: load the IR and old_pc.
- `pc_we` out 1: load the PC.
- `pc_sel` out 2: PC source; 0 = PC+4, 1 = old_pc+imm (branch/JAL), 2 = ALU result & ~1 (JALR).
- `rf_we` out 1: register file write.
- `imm_sel` out 3: immediate format; 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- `alu_src_a` out 1: ALU A operand; 0 = rs1, 1 = old_pc.
- `alu_src_b` out 1: ALU B operand; 0 = rs2, 1 = immediate.
- `wb_sel` out 2: writeback source; 0 = ALU, 1 = load data, 2 = old_pc+4, 3 = immediate (LUI).
- `state` out 3: current state, for debug.
- `trap` out 1: illegal-instruction or bus-error trap, sticky.
- `bus_err` out 1: the trap was caused by a memory timeout, sticky.

## Operation
- States are IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP. Reset enters IDLE; IDLE always moves to FETCH on the next clock.
- All outputs are Moore/decoded from the state register and `instr[6:0]`. Every enable is 0 in IDLE and in TRAP.
- **FETCH:** hold `imem_req`=1 until `mem_ready`. In the `mem_ready` cycle, pulse `ir_we` and `pc_we` with `pc_sel`=0, then go to DECODE.
- **DECODE:** one cycle. `imm_sel` is driven from the opcode and held stable through EXEC, MEM and WB.
- **EXEC, by opcode:**
  - OP (0110011): go to WB.
  - OP-IMM (0010011): `alu_src_b`=1, go to WB.
  - LOAD (0000011), STORE (0100011): `alu_src_b`=1, go to MEM.
  - LUI (0110111): go to WB.
  - AUIPC (0010111): `alu_src_a`=1, `alu_src_b`=1, go to WB.
  - BRANCH (1100011): if `branch_taken`, `pc_we`=1 with `pc_sel`=1; go to FETCH either way.
  - JAL (1101111): `rf_we`=1, `wb_sel`=2, `pc_we`=1, `pc_sel`=1; go to FETCH.
  - JALR (1100111): `alu_src_b`=1, `rf_we`=1, `wb_sel`=2, `pc_we`=1, `pc_sel`=2; go to FETCH.
- **MEM:** hold `dmem_req`=1 (`dmem_we`=1 for a store) until `mem_ready`. A store then goes to FETCH; a load goes to WB.
- **WB:** one cycle with `rf_we`=1; `wb_sel` is 1 for a load, 3 for LUI, 0 otherwise. Then go to FETCH.
- `rf_we` is suppressed whenever `instr[11:7]`==0.
- **Timeout counter:** 8 bits. It clears on entry to FETCH or MEM and increments on each wait cycle with `mem_ready`=0. When it reaches `MEM_TIMEOUT`, go to TRAP and set `bus_err`=1.
- **TRAP:** `trap`=1 and no exit except reset.

## Timing
- Reset values, asserted immediately on `rst_n` low: state=IDLE; all enables, `trap` and `bus_err` are 0. All selects are 0.
- Reset mid-instruction aborts it: no partial register or memory write completes after `rst_n` falls.
- `imem_req` first asserts one clock after reset release, because IDLE lasts one cycle.
- Cycles per instruction with zero-wait memory, counted from FETCH entry:
  - branch, JAL, JALR: 3
  - ALU, LUI, AUIPC, store: 4
  - load: 5
- Each memory wait cycle adds one cycle.
- `mem_ready` is ignored outside FETCH and MEM.
- `mem_ready` arriving in the same cycle the counter hits `MEM_TIMEOUT`: the handshake wins and no trap is taken.

## Configuration
- `ILLEGAL_TRAP_EN` defined: an opcode outside the nine listed goes from EXEC to TRAP with `trap`=1 and `bus_err`=0.
- `ILLEGAL_TRAP_EN` undefined: an unknown opcode executes as a NOP, going EXEC→FETCH with no writes.

## Structure
- Package `rv_ctrl_pkg` holds:
  - the opcode constants;
  - the state enum;
  - the `imm_sel`, `pc_sel` and `wb_sel` encodings.
- The datapath's `imm_gen` shares the `imm_sel` encodings from `rv_ctrl_pkg`.
- Sub-module `ctrl_decode` is a combinational opcode → instruction class/`imm_sel` decoder, instantiated once. The FSM and timeout counter stay in `multicycle_ctrl`.

## Test plan
- **ADDI:** `instr`=0xf9c30293 (addi x5,x6,-100), `mem_ready` tied 1. Required: states FETCH, DECODE, EXEC, WB; `imm_sel`=0; `alu_src_b`=1; `rf_we`=1 in WB only.
- **Load vs store:** 0x0c832283 (lw) takes 5 cycles, with `dmem_req`=1 and `dmem_we`=0 in MEM and `wb_sel`=1 in WB. 0x... sw equivalent: `dmem_we`=1, 4 cycles, and no `rf_we`.
- **Branch:** 0x02528063 (beq) with `branch_taken`=1 gives `pc_we`=1 and `pc_sel`=1 in EXEC. With `branch_taken`=0 there is no `pc_we` in EXEC. Both take 3 cycles.
- **JALR and rd=x0:** 0x100302e7 (jalr x5) in EXEC gives `rf_we`=1, `wb_sel`=2, `pc_sel`=2. An instruction with rd=x0 (0x00000013) shows no `rf_we`.
- **Timeout:** hold `mem_ready`=0 in FETCH for `MEM_TIMEOUT` cycles. Required: TRAP, `trap`=1 and `bus_err`=1, both sticky until `rst_n` pulses low. Then `mem_ready`=1 on the final count cycle: no trap.
- **Reset mid-MEM, then illegal opcode:** `rst_n` low during a store gives all enables 0 immediately, then IDLE followed by FETCH. Opcode 0x0000007f: with `ILLEGAL_TRAP_EN` it traps; without it, it runs as a 3-cycle NOP.
